serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial ripple adder that time-multiplexes a single `fullAdder1` slice over WIDTH cycles. It adds two WIDTH-bit operands and a carry-in, least significant bit first. A registered carry is fed back into `Cin` on each cycle. It sits directly upstream of the `fullAdder1` slice, feeding it one operand bit pair per cycle and consuming its `sum1`/`Cout` outputs. It gives area-constrained datapaths an N-bit add without N adder cells.

## Interface
- `WIDTH`, default 8: operand and result width in bits; must be ≥ 1.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  — single clock; all state changes on its rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `start`  in  1  — request to begin an add; sampled only when `busy`=0.
- `op_a`  in  WIDTH  — operand A; captured on the accepted `start` edge.
- `op_b`  in  WIDTH  — operand B; captured on the accepted `start` edge.
- `cin`  in  1  — carry-in; captured on the accepted `start` edge.
- `busy`  out  1  — high in the SHIFT and DONE states.
- `done`  out  1  — one-cycle pulse: `sum`/`cout` have just been updated.
- `sum`  out  WIDTH  — registered result, held until the next completion.
- `cout`  out  1  — registered carry-out, held until the next completion.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - `start`=1 → load `op_a`/`op_b` into shift registers A and B.
  - Load carry register with `cin`, clear bit counter, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT, on each edge:
  - `fullAdder1` inputs: `a`=A[0], `b`=B[0], `Cin`=carry register.
  - Shift A and B right by one.
  - Shift `sum1` into the MSB of the internal result shift register S.
  - Carry register ← `Cout`; counter +1.
  - On the edge that processes bit WIDTH-1: `sum`←final S value (including that bit), `cout`←`Cout`, go to DONE.
- DONE: `done`=1 for exactly one cycle, then unconditionally go to IDLE.
- Arithmetic:
  - {`cout`,`sum`} = `op_a` + `op_b` + `cin`, computed exactly at WIDTH+1 bits.
  - No overflow flag; wrap-around is modulo 2^WIDTH, with bit WIDTH reported on `cout`.
- Counter width: $clog2(WIDTH+1). The terminal compare is counter == WIDTH-1.
- `start` while `busy`=1 (SHIFT or DONE) is ignored. The operands in flight are unaffected, and no queueing occurs.
- Input changes on `op_a`/`op_b`/`cin` outside the accepted `start` edge have no effect.

## Timing
- Reset values: `busy`=0, `done`=0, `sum`=0, `cout`=0, state IDLE. Internal A, B, S, carry and counter are all 0.
- Latency:
  - `start` accepted at edge 0; bits are processed on edges 1..WIDTH.
  - `done`, `sum` and `cout` are valid after edge WIDTH.
  - `busy` falls after edge WIDTH+1.
- Throughput: one add per WIDTH+2 cycles. The earliest next accepted `start` is edge WIDTH+2.
- `busy` rises after edge 0, the same edge that accepts `start`.
- Reset mid-operation (SHIFT or DONE):
  - Immediate return to IDLE; all outputs take their reset values.
  - No `done` pulse; the partial result is discarded.
- `start` held continuously high: a new add is accepted on every IDLE cycle, i.e. back-to-back every WIDTH+2 cycles.
- WIDTH=1: a single SHIFT cycle, then DONE.

## Structure
- Package `serial_adder_pkg`: `typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t`.
- One sub-module instance: the existing `fullAdder1` (ports `a`, `b`, `Cin`, `sum1`, `Cout`) as the bit slice. No new adder logic is written in this block.
- Registers: A, B, S (WIDTH each), carry (1), counter, state, `sum`/`cout` output registers.

## Test plan
All scenarios use WIDTH=8.
- Reset: `rst` pulse at time 0 → `busy`=0, `done`=0, `sum`=8'h00, `cout`=0.
- 8'h35 + 8'h4A, `cin`=0 → `sum`=8'h7F, `cout`=0; `done` pulses exactly after edge 8 following the `start` edge.
- 8'hFF + 8'h01, `cin`=0 → `sum`=8'h00, `cout`=1. Covers full carry ripple and wrap-around.
- 8'hFF + 8'hFF, `cin`=1 → `sum`=8'hFF, `cout`=1.
- Ignored `start`:
  - Start 8'h10 + 8'h20; at SHIFT cycle 3, pulse `start` with 8'hAA + 8'h55.
  - → a single `done` with `sum`=8'h30.
  - The ignored request produces no second `done`.
- Reset mid-SHIFT:
  - After 8'h0F + 8'h01 completes (`sum`=8'h10), start 8'h12 + 8'h34; assert `rst` at SHIFT cycle 4.
  - → `busy`=0 and `sum`=8'h00 immediately; no `done` follows.
  - A following 8'h12 + 8'h34 then yields `sum`=8'h46.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/fullAdder1.sv
// One-bit full adder slice reused every cycle by serial_adder.
module fullAdder1 (
  input  logic a,
  input  logic b,
  input  logic Cin,
  output logic sum1,
  output logic Cout
);

  assign sum1 = a ^ b ^ Cin;
  assign Cout = (a & b) | (a & Cin) | (b & Cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one fullAdder1 slice processes operands LSB first over
// WIDTH cycles, with the carry registered between bits.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state, state_next;
  logic [WIDTH-1:0] a_reg, b_reg, s_reg, s_next;
  logic             carry;
  logic [CNT_W-1:0] count;
  logic             sum1, slice_cout;
  logic             last_bit;

  fullAdder1 u_slice (
    .a    (a_reg[0]),
    .b    (b_reg[0]),
    .Cin  (carry),
    .sum1 (sum1),
    .Cout (slice_cout)
  );

  // New bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
  if (WIDTH == 1) begin : g_single
    assign s_next = sum1;
  end else begin : g_multi
    assign s_next = {sum1, s_reg[WIDTH-1:1]};
  end

  assign last_bit = (count == LAST_BIT);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: the default assignment first keeps this block free of latches.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg <= '0;
      b_reg <= '0;
      s_reg <= '0;
      carry <= 1'b0;
      count <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a_reg <= op_a;
            b_reg <= op_b;
            carry <= cin;
            count <= '0;
          end
        end
        SHIFT: begin
          a_reg <= a_reg >> 1;
          b_reg <= b_reg >> 1;
          s_reg <= s_next;
          carry <= slice_cout;
          count <= count + 1'b1;
          if (last_bit) begin
            sum  <= s_next;
            cout <= slice_cout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder (WIDTH=8): driver pushes expected results,
// a monitor pops and compares on every done pulse, including done timing.
module tb_serial_adder;

  localparam int WIDTH = 8;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    int               start_cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] op_a, op_b;
  logic             cin;
  logic             busy, done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   done_seen = 0;
  exp_t sb[$];

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op_a  (op_a),
    .op_b  (op_b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: any done with an empty scoreboard is a spurious completion.
  always @(negedge clk) begin
    if (!rst && done === 1'b1) begin
      done_seen++;
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sum", 32'(sum), 32'(e.sum));
        check("cout", 32'(cout), 32'(e.cout));
        check("done_latency", 32'(cyc - e.start_cyc), 32'(WIDTH));
      end
    end
  end

  // Issue one add; expected values are hand-computed by the caller.
  task automatic do_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic c, input logic [WIDTH-1:0] es, input logic ec);
    exp_t e;
    op_a  = a;
    op_b  = b;
    cin   = c;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    e.sum = es;
    e.cout = ec;
    e.start_cyc = cyc;
    sb.push_back(e);
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((sb.size() != 0 || busy !== 1'b0) && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, 32'(n < 60), 32'd1);
  endtask

  initial begin
    exp_t e;
    int   s0;
    rst   = 1'b1;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    cin   = 1'b0;
    #2;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_sum",  32'(sum),  32'd0);
    check("reset_cout", 32'(cout), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    do_add(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0);
    wait_drain("drain_35_4a");
    do_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    wait_drain("drain_ff_01");
    do_add(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    wait_drain("drain_ff_ff");
    do_add(8'h00, 8'h00, 1'b1, 8'h01, 1'b0);
    wait_drain("drain_00_00");

    // Start pulsed during SHIFT cycle 3 must be ignored.
    do_add(8'h10, 8'h20, 1'b0, 8'h30, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    op_a  = 8'hAA;
    op_b  = 8'h55;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_drain("drain_ignored_start");
    repeat (15) @(posedge clk);
    #1;
    check("no_second_done_busy", 32'(busy), 32'd0);

    // Reset in the middle of an operation discards it.
    do_add(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0);
    wait_drain("drain_0f_01");
    check("held_sum", 32'(sum), 32'h10);
    op_a  = 8'h12;
    op_b  = 8'h34;
    cin   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_sum",  32'(sum),  32'd0);
    check("midreset_cout", 32'(cout), 32'd0);
    check("midreset_done", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    do_add(8'h12, 8'h34, 1'b0, 8'h46, 1'b0);
    wait_drain("drain_12_34");

    // Start held high: back-to-back adds every WIDTH+2 cycles.
    op_a  = 8'h11;
    op_b  = 8'h22;
    cin   = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    s0 = cyc;
    e.sum = 8'h34; e.cout = 1'b0; e.start_cyc = s0;
    sb.push_back(e);
    repeat (WIDTH + 2) @(posedge clk);
    #1;
    start = 1'b0;
    e.start_cyc = s0 + WIDTH + 2;
    sb.push_back(e);
    check("b2b_busy", 32'(busy), 32'd1);
    wait_drain("drain_b2b");

    repeat (5) @(posedge clk);
    #1;
    check("done_count", 32'(done_seen), 32'd9);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
